cheat_engine: RTL and testbench
===============================

Name: cheat_engine

Overview:
- Parametrised successor to the NES Game Genie code table: holds up to MAX_CODES cheat entries, loaded through a valid/ready command port.
- Two entry types:
  - Read-override: forces CPU read data, with optional compare.
  - Freeze: writes a value to RAM through a round-robin write sequencer during idle bus slots.
- Sits between the cheat loader (HPS/OSD path) and the CPU bus mux.

Parameters:
MAX_CODES, 32, number of table entries (power of two, 2..64)
ADDR_W, 16, bus address width
DATA_W, 8, bus data width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  global cheat enable; gates ovr and the freeze sequencer
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready
cmd_op  in  2  0=add/update, 1=delete by address, 2=clear all, 3=nop
cmd_type  in  1  0=read-override, 1=freeze
cmd_cmp_en  in  1  compare enable (override entries only)
cmd_addr  in  ADDR_W  entry address
cmd_cmp  in  DATA_W  compare value
cmd_data  in  DATA_W  replace/freeze value
cmd_done  out  1  1-cycle pulse when a command completes
cmd_err  out  1  1-cycle pulse with cmd_done: add while full, or delete not found
count  out  $clog2(MAX_CODES+1)  number of valid entries
full  out  1  count == MAX_CODES
addr_in  in  ADDR_W  CPU read address
data_in  in  DATA_W  original read data
ovr  out  1  override active (combinational)
ovr_data  out  DATA_W  replacement data (combinational)
slot  in  1  1-cycle pulse: bus free for one injected write
wr_req  out  1  freeze write request
wr_addr  out  ADDR_W  freeze write address
wr_data  out  DATA_W  freeze write data
wr_ack  in  1  write taken

Behaviour:
- Entry fields: valid, type, cmp_en, addr, cmp, data. IW = $clog2(MAX_CODES).
- Reset: all entries invalid; both FSMs idle; scan/freeze pointers 0.
  - Outputs after reset: cmd_ready=1, cmd_done=0, cmd_err=0, count=0, full=0, wr_req=0, wr_addr=0, wr_data=0, ovr=0.
  - Reset mid-command or mid-request abandons the operation without completion or ack.
- Command FSM states: IDLE, SCAN, COMMIT, CLEAR.
  - cmd_ready=1 only in IDLE.
  - On acceptance, the command is latched.
  - nop: immediate cmd_done with no state change.
- Add/delete: SCAN examines one entry per cycle, index 0..MAX_CODES-1, recording:
  - the first valid entry whose addr equals the latched addr (match);
  - the first invalid entry (free).
- After the last index, COMMIT (1 cycle) applies the result and pulses cmd_done. Total latency from accept to cmd_done = MAX_CODES+1 cycles.
- Add resolution:
  - Match found: overwrite that entry in place; count unchanged.
  - No match, free found: write the free entry; count+1.
  - No match, no free: no change; cmd_err=1.
- Delete resolution:
  - Match found: invalidate the entry; count-1.
  - No match: cmd_err=1.
- Clear: CLEAR invalidates all entries in 1 cycle, sets count=0, pulses cmd_done 1 cycle after accept.
- Override path (combinational), active only when enable=1:
  - A hit is any valid type-0 entry with addr==addr_in and (cmp_en==0 or cmp==data_in).
  - On a hit, ovr=1 and ovr_data=data of the lowest-index hit.
  - Otherwise ovr=0, ovr_data=0.
  - Table writes become visible on the cycle after COMMIT.
- Freeze FSM states: F_IDLE, F_SEEK, F_REQ.
  - F_IDLE: on slot && enable with at least one valid freeze entry, go to F_SEEK. A slot while busy is ignored.
  - F_SEEK: tests entry fptr each cycle. If it is a valid freeze entry, latch wr_addr/wr_data and go to F_REQ; otherwise fptr+1 (wraps at MAX_CODES-1→0). Abort to F_IDLE if that entry was deleted before being reached.
  - F_REQ: wr_req=1 and latched values are held stable until wr_ack. Deletion or enable going low does not drop the request. On wr_ack: wr_req=0 next cycle, fptr+1 (wrap), return to F_IDLE.
  - Round-robin: successive slots service successive freeze entries.
- Command processing and freeze sequencing run concurrently. A freeze latch in the same cycle as a COMMIT reads the pre-commit entry value.

Test Plan:
- Add override {addr 0x8123, cmp_en 0, data 0xEA}; read addr_in=0x8123 → ovr=1, ovr_data=0xEA; addr 0x8124 → ovr=0. cmd_done 33 cycles after accept; count=1.
- Add override {0x9000, cmp_en 1, cmp 0x05, data 0x09}; data_in=0x05 → ovr=1, 0x09; data_in=0x06 → ovr=0. Re-add 0x9000 with data 0x0A → count stays 2; data_in=0x05 now reads 0x0A.
- Fill 32 entries, then add a new address → cmd_err=1, count=32, full=1. Delete 0x7777 (absent) → cmd_err=1. Delete an existing address → count=31, full=0.
- Freeze entries at 0x0010 (data 0x63) and 0x0020 (data 0x09), with override entries in between. Three slots with wr_ack asserted 2 cycles after wr_req → writes in order (0x0010,0x63), (0x0020,0x09), (0x0010,0x63); wr_addr/wr_data stable while wr_req=1.
- Delete freeze 0x0010 while its wr_req is pending → request held until ack. Next slot → only 0x0020 is written.
- Clear while freeze requesting, then reset during SCAN of an add → count=0, wr_req=0, cmd_ready=1 after reset, no cmd_done. With enable=0 → ovr=0 and slot is ignored.

Source files
------------

// File: rtl/cheat_engine.sv
// cheat_engine: cheat code table with combinational read override and a
// round-robin freeze write sequencer that injects writes into free bus slots.

// Per-entry override hit: valid read-override entry whose address matches,
// with the compare value honoured only when cmp_en is set.
module cheat_engine_match #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
) (
  input  logic              valid,
  input  logic              frz,
  input  logic              cmp_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] cmp,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              hit
);
  assign hit = valid && !frz && (addr == addr_in) && (!cmp_en || (cmp == data_in));
endmodule

module cheat_engine #(
  parameter int MAX_CODES = 32,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic                           cmd_type,
  input  logic                           cmd_cmp_en,
  input  logic [ADDR_W-1:0]              cmd_addr,
  input  logic [DATA_W-1:0]              cmd_cmp,
  input  logic [DATA_W-1:0]              cmd_data,
  output logic                           cmd_done,
  output logic                           cmd_err,
  output logic [$clog2(MAX_CODES+1)-1:0] count,
  output logic                           full,
  input  logic [ADDR_W-1:0]              addr_in,
  input  logic [DATA_W-1:0]              data_in,
  output logic                           ovr,
  output logic [DATA_W-1:0]              ovr_data,
  input  logic                           slot,
  output logic                           wr_req,
  output logic [ADDR_W-1:0]              wr_addr,
  output logic [DATA_W-1:0]              wr_data,
  input  logic                           wr_ack
);
  localparam int IW = $clog2(MAX_CODES);
  localparam int CW = $clog2(MAX_CODES+1);
  localparam logic [IW-1:0] LAST = IW'(MAX_CODES-1);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, CLEAR} cmd_state_t;
  typedef enum logic [1:0] {F_IDLE, F_SEEK, F_REQ} frz_state_t;

  // entry table
  logic [MAX_CODES-1:0]             ent_valid, ent_type, ent_cmp_en;
  logic [MAX_CODES-1:0][ADDR_W-1:0] ent_addr;
  logic [MAX_CODES-1:0][DATA_W-1:0] ent_cmp, ent_data;

  // command path state
  cmd_state_t        cstate;
  logic [1:0]        l_op;
  logic              l_type, l_cmp_en;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_cmp, l_data;
  logic [IW-1:0]     scan_idx, match_idx, free_idx, put_idx;
  logic              match_hit, free_hit;

  // freeze path state
  frz_state_t        fstate;
  logic [IW-1:0]     fptr, fptr_nxt;
  logic              any_freeze;

  logic [MAX_CODES-1:0] hit;

  assign full       = (count == CW'(MAX_CODES));
  assign put_idx    = match_hit ? match_idx : free_idx;
  assign any_freeze = |(ent_valid & ent_type);
  assign fptr_nxt   = (fptr == LAST) ? '0 : fptr + 1'b1;

  for (genvar g = 0; g < MAX_CODES; g++) begin : g_match
    cheat_engine_match #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match (
      .valid   (ent_valid[g]),
      .frz     (ent_type[g]),
      .cmp_en  (ent_cmp_en[g]),
      .addr    (ent_addr[g]),
      .cmp     (ent_cmp[g]),
      .addr_in (addr_in),
      .data_in (data_in),
      .hit     (hit[g])
    );
  end

  // Override mux: walk high to low so the lowest-index hit wins.
  always_comb begin
    ovr      = 1'b0;
    ovr_data = '0;
    for (int i = MAX_CODES-1; i >= 0; i--) begin
      if (enable && hit[i]) begin
        ovr      = 1'b1;
        ovr_data = ent_data[i];
      end
    end
  end

  // Command FSM: accept, linear scan for match/free, then single-cycle commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      cstate    <= IDLE;
      cmd_ready <= 1'b1;
      cmd_done  <= 1'b0;
      cmd_err   <= 1'b0;
      count     <= '0;
      ent_valid <= '0;
      l_op      <= 2'd3;
      l_type    <= 1'b0;
      l_cmp_en  <= 1'b0;
      l_addr    <= '0;
      l_cmp     <= '0;
      l_data    <= '0;
      scan_idx  <= '0;
      match_hit <= 1'b0;
      match_idx <= '0;
      free_hit  <= 1'b0;
      free_idx  <= '0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (cstate)
        IDLE: if (cmd_valid) begin
          l_op      <= cmd_op;
          l_type    <= cmd_type;
          l_cmp_en  <= cmd_cmp_en;
          l_addr    <= cmd_addr;
          l_cmp     <= cmd_cmp;
          l_data    <= cmd_data;
          scan_idx  <= '0;
          match_hit <= 1'b0;
          free_hit  <= 1'b0;
          case (cmd_op)
            2'd0, 2'd1: begin cstate <= SCAN;  cmd_ready <= 1'b0; end
            2'd2:       begin cstate <= CLEAR; cmd_ready <= 1'b0; end
            default:    cmd_done <= 1'b1;
          endcase
        end
        SCAN: begin
          if (ent_valid[scan_idx] && (ent_addr[scan_idx] == l_addr) && !match_hit) begin
            match_hit <= 1'b1;
            match_idx <= scan_idx;
          end
          if (!ent_valid[scan_idx] && !free_hit) begin
            free_hit <= 1'b1;
            free_idx <= scan_idx;
          end
          if (scan_idx == LAST) cstate <= COMMIT;
          else                  scan_idx <= scan_idx + 1'b1;
        end
        COMMIT: begin
          cstate    <= IDLE;
          cmd_ready <= 1'b1;
          cmd_done  <= 1'b1;
          if (l_op == 2'd0) begin
            if (match_hit || free_hit) begin
              ent_valid[put_idx]  <= 1'b1;
              ent_type[put_idx]   <= l_type;
              ent_cmp_en[put_idx] <= l_cmp_en;
              ent_addr[put_idx]   <= l_addr;
              ent_cmp[put_idx]    <= l_cmp;
              ent_data[put_idx]   <= l_data;
              if (!match_hit) count <= count + 1'b1;
            end else begin
              cmd_err <= 1'b1;
            end
          end else if (match_hit) begin
            ent_valid[match_idx] <= 1'b0;
            count                <= count - 1'b1;
          end else begin
            cmd_err <= 1'b1;
          end
        end
        CLEAR: begin
          ent_valid <= '0;
          count     <= '0;
          cstate    <= IDLE;
          cmd_ready <= 1'b1;
          cmd_done  <= 1'b1;
        end
        default: cstate <= IDLE;
      endcase
    end
  end

  // Freeze sequencer: on a free slot, seek the next valid freeze entry from
  // fptr and hold a write request until acked. Once latched, the request is
  // independent of the table and of enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      fstate  <= F_IDLE;
      fptr    <= '0;
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      case (fstate)
        F_IDLE: if (slot && enable && any_freeze) fstate <= F_SEEK;
        F_SEEK: begin
          if (ent_valid[fptr] && ent_type[fptr]) begin
            wr_addr <= ent_addr[fptr];
            wr_data <= ent_data[fptr];
            wr_req  <= 1'b1;
            fstate  <= F_REQ;
          end else if (!any_freeze) begin
            fstate <= F_IDLE;
          end else begin
            fptr <= fptr_nxt;
          end
        end
        F_REQ: if (wr_ack) begin
          wr_req <= 1'b0;
          fptr   <= fptr_nxt;
          fstate <= F_IDLE;
        end
        default: fstate <= F_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cheat_engine.sv
// Directed bench for cheat_engine: command latency, override, full table,
// freeze round-robin, clear/reset abandonment and enable gating.
module tb_cheat_engine;
  logic        clk = 1'b0, reset = 1'b1, enable = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic [1:0]  cmd_op = 2'd3;
  logic        cmd_type = 1'b0, cmd_cmp_en = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_cmp = '0, cmd_data = '0;
  logic        cmd_done, cmd_err;
  logic [5:0]  count;
  logic        full;
  logic [15:0] addr_in = '0;
  logic [7:0]  data_in = '0;
  logic        ovr;
  logic [7:0]  ovr_data;
  logic        slot = 1'b0, wr_req, wr_ack = 1'b0;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;

  int n_chk = 0, n_fail = 0;

  cheat_engine #(.MAX_CODES(32), .ADDR_W(16), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_type(cmd_type), .cmd_cmp_en(cmd_cmp_en), .cmd_addr(cmd_addr),
    .cmd_cmp(cmd_cmp), .cmd_data(cmd_data), .cmd_done(cmd_done),
    .cmd_err(cmd_err), .count(count), .full(full),
    .addr_in(addr_in), .data_in(data_in), .ovr(ovr), .ovr_data(ovr_data),
    .slot(slot), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; cmd_valid = 1'b0; slot = 1'b0; wr_ack = 1'b0; enable = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Issue one command; lat = edges from accept until cmd_done is seen (-1 on timeout).
  task automatic send_cmd(input logic [1:0] op, input logic typ, input logic cen,
                          input logic [15:0] a, input logic [7:0] c, input logic [7:0] d,
                          output int lat, output logic err);
    int w = 0;
    while (!cmd_ready && w < 200) begin tick(); w++; end
    cmd_valid = 1'b1; cmd_op = op; cmd_type = typ; cmd_cmp_en = cen;
    cmd_addr = a; cmd_cmp = c; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    lat = 0; err = 1'b0;
    while (!cmd_done && lat < 200) begin tick(); lat++; end
    if (!cmd_done) lat = -1;
    else err = cmd_err;
  endtask

  // Pulse slot, wait for wr_req, watch it for dly cycles, optionally ack.
  task automatic do_slot(input int dly, input bit do_ack, output logic [15:0] a,
                         output logic [7:0] d, output bit ok, output bit seen);
    int w = 0;
    slot = 1'b1; tick(); slot = 1'b0;
    while (!wr_req && w < 100) begin tick(); w++; end
    seen = wr_req; a = wr_addr; d = wr_data; ok = 1'b1;
    if (seen) begin
      for (int i = 0; i < dly; i++) begin
        tick();
        if (wr_req !== 1'b1 || wr_addr !== a || wr_data !== d) ok = 1'b0;
      end
      if (do_ack) begin
        wr_ack = 1'b1; tick(); wr_ack = 1'b0;
        if (wr_req !== 1'b0) ok = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if ({cmd_ready, cmd_done, cmd_err} !== 3'b100) begin n_fail++;
      $display("FAIL reset_cmd: ready/done/err=%b want 100", {cmd_ready, cmd_done, cmd_err}); end
    n_chk++; if (count !== 6'd0 || full !== 1'b0) begin n_fail++;
      $display("FAIL reset_count: count=%0d full=%b want 0 0", count, full); end
    n_chk++; if ({wr_req, wr_addr, wr_data, ovr} !== 26'd0) begin n_fail++;
      $display("FAIL reset_wr: wr_req=%b wr_addr=%h wr_data=%h ovr=%b want all 0", wr_req, wr_addr, wr_data, ovr); end
  endtask

  task automatic test_nop();
    int lat; logic err;
    send_cmd(2'd3, 1'b0, 1'b0, 16'h1111, 8'h00, 8'h00, lat, err);
    n_chk++; if (lat !== 0 || err !== 1'b0 || count !== 6'd0) begin n_fail++;
      $display("FAIL nop: lat=%0d err=%b count=%0d want 0 0 0", lat, err, count); end
  endtask

  task automatic test_override();
    int lat; logic err;
    send_cmd(2'd0, 1'b0, 1'b0, 16'h8123, 8'h00, 8'hEA, lat, err);
    n_chk++; if (lat !== 33 || err !== 1'b0) begin n_fail++;
      $display("FAIL add_latency: lat=%0d err=%b want 33 0", lat, err); end
    tick();
    n_chk++; if (cmd_done !== 1'b0 || count !== 6'd1) begin n_fail++;
      $display("FAIL add_pulse: cmd_done=%b count=%0d want 0 1", cmd_done, count); end
    addr_in = 16'h8123; data_in = 8'h00; #1;
    n_chk++; if (ovr !== 1'b1 || ovr_data !== 8'hEA) begin n_fail++;
      $display("FAIL ovr_hit: ovr=%b data=%h want 1 ea", ovr, ovr_data); end
    addr_in = 16'h8124; #1;
    n_chk++; if (ovr !== 1'b0 || ovr_data !== 8'h00) begin n_fail++;
      $display("FAIL ovr_miss: ovr=%b data=%h want 0 00", ovr, ovr_data); end
  endtask

  task automatic test_compare();
    int lat; logic err;
    send_cmd(2'd0, 1'b0, 1'b1, 16'h9000, 8'h05, 8'h09, lat, err);
    n_chk++; if (count !== 6'd2 || err !== 1'b0) begin n_fail++;
      $display("FAIL cmp_add: count=%0d err=%b want 2 0", count, err); end
    addr_in = 16'h9000; data_in = 8'h05; #1;
    n_chk++; if (ovr !== 1'b1 || ovr_data !== 8'h09) begin n_fail++;
      $display("FAIL cmp_hit: ovr=%b data=%h want 1 09", ovr, ovr_data); end
    data_in = 8'h06; #1;
    n_chk++; if (ovr !== 1'b0) begin n_fail++;
      $display("FAIL cmp_miss: ovr=%b want 0", ovr); end
    send_cmd(2'd0, 1'b0, 1'b1, 16'h9000, 8'h05, 8'h0A, lat, err);
    n_chk++; if (count !== 6'd2 || err !== 1'b0) begin n_fail++;
      $display("FAIL readd: count=%0d err=%b want 2 0", count, err); end
    addr_in = 16'h9000; data_in = 8'h05; #1;
    n_chk++; if (ovr !== 1'b1 || ovr_data !== 8'h0A) begin n_fail++;
      $display("FAIL readd_data: ovr=%b data=%h want 1 0a", ovr, ovr_data); end
  endtask

  task automatic test_full();
    int lat; logic err;
    for (int i = 0; i < 30; i++)
      send_cmd(2'd0, 1'b0, 1'b0, 16'h1000 + 16'(i), 8'h00, 8'(i), lat, err);
    n_chk++; if (count !== 6'd32 || full !== 1'b1) begin n_fail++;
      $display("FAIL fill: count=%0d full=%b want 32 1", count, full); end
    send_cmd(2'd0, 1'b0, 1'b0, 16'h5555, 8'h00, 8'h01, lat, err);
    n_chk++; if (err !== 1'b1 || count !== 6'd32 || lat !== 33) begin n_fail++;
      $display("FAIL add_full: err=%b count=%0d lat=%0d want 1 32 33", err, count, lat); end
    send_cmd(2'd0, 1'b0, 1'b0, 16'h8123, 8'h00, 8'h55, lat, err);
    addr_in = 16'h8123; #1;
    n_chk++; if (err !== 1'b0 || ovr_data !== 8'h55 || count !== 6'd32) begin n_fail++;
      $display("FAIL update_full: err=%b data=%h count=%0d want 0 55 32", err, ovr_data, count); end
    send_cmd(2'd1, 1'b0, 1'b0, 16'h7777, 8'h00, 8'h00, lat, err);
    n_chk++; if (err !== 1'b1 || count !== 6'd32) begin n_fail++;
      $display("FAIL del_absent: err=%b count=%0d want 1 32", err, count); end
    send_cmd(2'd1, 1'b0, 1'b0, 16'h1000, 8'h00, 8'h00, lat, err);
    n_chk++; if (err !== 1'b0 || count !== 6'd31 || full !== 1'b0) begin n_fail++;
      $display("FAIL del_hit: err=%b count=%0d full=%b want 0 31 0", err, count, full); end
    addr_in = 16'h1000; #1;
    n_chk++; if (ovr !== 1'b0) begin n_fail++;
      $display("FAIL del_ovr: ovr=%b want 0", ovr); end
    send_cmd(2'd0, 1'b0, 1'b0, 16'h5555, 8'h00, 8'h01, lat, err);
    n_chk++; if (err !== 1'b0 || count !== 6'd32) begin n_fail++;
      $display("FAIL reuse_free: err=%b count=%0d want 0 32", err, count); end
  endtask

  task automatic test_freeze();
    int lat; logic err;
    logic [15:0] a; logic [7:0] d; bit ok, seen;
    logic [15:0] exp_a [3] = '{16'h0010, 16'h0020, 16'h0010};
    logic [7:0]  exp_d [3] = '{8'h63, 8'h09, 8'h63};
    do_reset();
    send_cmd(2'd0, 1'b1, 1'b0, 16'h0010, 8'h00, 8'h63, lat, err);
    send_cmd(2'd0, 1'b0, 1'b0, 16'h0015, 8'h00, 8'h77, lat, err);
    send_cmd(2'd0, 1'b1, 1'b0, 16'h0020, 8'h00, 8'h09, lat, err);
    send_cmd(2'd0, 1'b0, 1'b0, 16'h0018, 8'h00, 8'h78, lat, err);
    addr_in = 16'h0010; #1;
    n_chk++; if (ovr !== 1'b0) begin n_fail++;
      $display("FAIL frz_no_ovr: ovr=%b want 0", ovr); end
    for (int k = 0; k < 3; k++) begin
      do_slot(2, 1'b1, a, d, ok, seen);
      n_chk++; if (!seen || !ok || a !== exp_a[k] || d !== exp_d[k]) begin n_fail++;
        $display("FAIL frz_rr%0d: seen=%b ok=%b addr=%h data=%h want 1 1 %h %h", k, seen, ok, a, d, exp_a[k], exp_d[k]); end
    end
    do_slot(1, 1'b1, a, d, ok, seen);
    do_slot(0, 1'b0, a, d, ok, seen);
    n_chk++; if (!seen || a !== 16'h0010) begin n_fail++;
      $display("FAIL frz_pend: seen=%b addr=%h want 1 0010", seen, a); end
    send_cmd(2'd1, 1'b0, 1'b0, 16'h0010, 8'h00, 8'h00, lat, err);
    n_chk++; if (err !== 1'b0 || wr_req !== 1'b1 || wr_addr !== 16'h0010 || wr_data !== 8'h63) begin n_fail++;
      $display("FAIL frz_hold: err=%b req=%b addr=%h data=%h want 0 1 0010 63", err, wr_req, wr_addr, wr_data); end
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    n_chk++; if (wr_req !== 1'b0) begin n_fail++;
      $display("FAIL frz_ack: wr_req=%b want 0", wr_req); end
    for (int k = 0; k < 2; k++) begin
      do_slot(1, 1'b1, a, d, ok, seen);
      n_chk++; if (!seen || !ok || a !== 16'h0020 || d !== 8'h09) begin n_fail++;
        $display("FAIL frz_after_del%0d: seen=%b ok=%b addr=%h data=%h want 1 1 0020 09", k, seen, ok, a, d); end
    end
  endtask

  task automatic test_clear_reset();
    int lat; logic err; bit done_seen;
    logic [15:0] a; logic [7:0] d; bit ok, seen;
    do_slot(0, 1'b0, a, d, ok, seen);
    send_cmd(2'd2, 1'b0, 1'b0, 16'h0000, 8'h00, 8'h00, lat, err);
    n_chk++; if (lat !== 1 || err !== 1'b0 || count !== 6'd0) begin n_fail++;
      $display("FAIL clear: lat=%0d err=%b count=%0d want 1 0 0", lat, err, count); end
    n_chk++; if (wr_req !== 1'b1 || wr_addr !== 16'h0020) begin n_fail++;
      $display("FAIL clear_hold: wr_req=%b addr=%h want 1 0020", wr_req, wr_addr); end
    addr_in = 16'h0015; #1;
    n_chk++; if (ovr !== 1'b0) begin n_fail++;
      $display("FAIL clear_ovr: ovr=%b want 0", ovr); end
    cmd_valid = 1'b1; cmd_op = 2'd0; cmd_type = 1'b0; cmd_cmp_en = 1'b0;
    cmd_addr = 16'h1234; cmd_data = 8'h44;
    tick(); cmd_valid = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_chk++; if (count !== 6'd0 || wr_req !== 1'b0 || cmd_ready !== 1'b1 || cmd_done !== 1'b0) begin n_fail++;
      $display("FAIL reset_scan: count=%0d req=%b ready=%b done=%b want 0 0 1 0", count, wr_req, cmd_ready, cmd_done); end
    done_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin tick(); if (cmd_done) done_seen = 1'b1; end
    addr_in = 16'h1234; #1;
    n_chk++; if (done_seen !== 1'b0 || ovr !== 1'b0) begin n_fail++;
      $display("FAIL reset_abandon: done_seen=%b ovr=%b want 0 0", done_seen, ovr); end
  endtask

  task automatic test_enable();
    int lat; logic err; bit req_seen;
    logic [15:0] a; logic [7:0] d; bit ok, seen;
    send_cmd(2'd0, 1'b0, 1'b0, 16'h4000, 8'h00, 8'h11, lat, err);
    send_cmd(2'd0, 1'b1, 1'b0, 16'h0030, 8'h00, 8'h22, lat, err);
    enable = 1'b0; addr_in = 16'h4000; #1;
    n_chk++; if (ovr !== 1'b0 || ovr_data !== 8'h00) begin n_fail++;
      $display("FAIL en_ovr: ovr=%b data=%h want 0 00", ovr, ovr_data); end
    slot = 1'b1; tick(); slot = 1'b0;
    req_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin tick(); if (wr_req) req_seen = 1'b1; end
    n_chk++; if (req_seen !== 1'b0) begin n_fail++;
      $display("FAIL en_slot: wr_req seen=%b want 0", req_seen); end
    enable = 1'b1; #1;
    n_chk++; if (ovr !== 1'b1 || ovr_data !== 8'h11) begin n_fail++;
      $display("FAIL en_ovr_on: ovr=%b data=%h want 1 11", ovr, ovr_data); end
    do_slot(2, 1'b1, a, d, ok, seen);
    n_chk++; if (!seen || !ok || a !== 16'h0030 || d !== 8'h22) begin n_fail++;
      $display("FAIL en_frz: seen=%b ok=%b addr=%h data=%h want 1 1 0030 22", seen, ok, a, d); end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_override();
    test_compare();
    test_full();
    test_freeze();
    test_clear_reset();
    test_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
